// File: rtl/yutorina_mem_stage_pkg.sv
// Shared codes for the MEM stage: memory ops, exception codes, control ops,
// bus widths and the bus FSM state encoding.
package yutorina_mem_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int BUS_ADDR_W = 30;
    localparam int GPR_ADDR_W = 5;
    localparam int EXP_W      = 3;
    localparam int CTRL_W     = 2;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LW   = 2'd1,
        MEM_SW   = 2'd2
    } mem_op_t;

    localparam logic [EXP_W-1:0]  EXP_NONE       = 3'd0;
    localparam logic [EXP_W-1:0]  EXP_MISS_ALIGN = 3'd4;
    localparam logic [CTRL_W-1:0] CTRL_NONE      = 2'd0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } bus_state_t;

    // Word accesses must have the two low address bits clear.
    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/yutorina_mem_stage_if.sv
// Memory bus between the MEM stage (master) and the memory (slave).
// Handshake: bus_req_ low asks for an access described by bus_addr/bus_rw/
// bus_wr_data; the access completes in the cycle the slave drives bus_rdy_
// low (bus_rd_data valid in that same cycle). The master keeps bus_req_ and
// the request fields stable until that completion cycle.
interface yutorina_mem_stage_if;
    import yutorina_mem_stage_pkg::*;

    logic                  bus_req_;
    logic [BUS_ADDR_W-1:0] bus_addr;
    logic                  bus_rw;
    logic [WORD_W-1:0]     bus_wr_data;
    logic [WORD_W-1:0]     bus_rd_data;
    logic                  bus_rdy_;

    modport master (
        output bus_req_, bus_addr, bus_rw, bus_wr_data,
        input  bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_addr, bus_rw, bus_wr_data,
        output bus_rd_data, bus_rdy_
    );

endinterface

// File: rtl/yutorina_mem_stage_bus_if.sv
// Bus handshake controller: decides whether the EX instruction needs a bus
// cycle, drives the request, tracks IDLE/ACCESS and reports busy.
module yutorina_bus_if
    import yutorina_mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                ex_en_,
    input  logic [EXP_W-1:0]    ex_exp_code,
    input  logic [1:0]          ex_mem_op,
    input  logic [WORD_W-1:0]   ex_out,
    input  logic [WORD_W-1:0]   ex_w_data,
    yutorina_mem_stage_if.master bus,
    output logic                busy,
    output logic                access_req,
    output logic                miss_align,
    output logic                discard,
    output bus_state_t          state
);

    logic mem_valid;
    logic done;

    // Classify the EX instruction: legal bus access or misaligned access.
    always_comb begin
        mem_valid  = !ex_en_ && (ex_exp_code == EXP_NONE) && (ex_mem_op != MEM_NONE);
        access_req = mem_valid && is_aligned(ex_out);
        miss_align = mem_valid && !is_aligned(ex_out);
    end

    // Request is combinational so a zero-wait slave can finish in one cycle.
    always_comb begin
        bus.bus_req_    = 1'b1;
        if (!rst && ((state == ACCESS) || access_req)) begin
            bus.bus_req_ = 1'b0;
        end
        bus.bus_addr    = ex_out[WORD_W-1:2];
        bus.bus_rw      = (ex_mem_op == MEM_LW);
        bus.bus_wr_data = ex_w_data;
        busy            = !bus.bus_req_ && bus.bus_rdy_;
        done            = !bus.bus_req_ && !bus.bus_rdy_;
    end

    // IDLE/ACCESS sequencing plus a sticky flag that drops the result of a
    // bus cycle that was flushed while still waiting for the slave.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (access_req && bus.bus_rdy_) state <= ACCESS;
                ACCESS:  if (!bus.bus_rdy_) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (done) begin
                discard <= 1'b0;
            end else if (flush && busy) begin
                discard <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/yutorina_mem_stage.sv
// MEM pipeline stage: issues loads/stores on the memory bus and holds the
// MEM/WB pipeline register.
module yutorina_mem_stage
    import yutorina_mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_en_,
    input  logic [GPR_ADDR_W-1:0] ex_w_addr,
    input  logic [WORD_W-1:0]     ex_w_data,
    input  logic                  ex_gpr_we_,
    input  logic [EXP_W-1:0]      ex_exp_code,
    input  logic [1:0]            ex_mem_op,
    input  logic [CTRL_W-1:0]     ex_ctrl_op,
    input  logic [WORD_W-1:0]     ex_out,
    yutorina_mem_stage_if.master  bus,
    output logic                  busy,
    output logic                  mem_en_,
    output logic [GPR_ADDR_W-1:0] mem_w_addr,
    output logic                  mem_gpr_we_,
    output logic [EXP_W-1:0]      mem_exp_code,
    output logic [CTRL_W-1:0]     mem_ctrl_op,
    output logic [WORD_W-1:0]     mem_out,
    output logic [GPR_ADDR_W-1:0] fwd_addr,
    output logic [WORD_W-1:0]     fwd_out,
    output bus_state_t            fsm_state
);

    logic access_req;
    logic miss_align;
    logic discard;

    yutorina_bus_if u_bus_if (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ex_en_      (ex_en_),
        .ex_exp_code (ex_exp_code),
        .ex_mem_op   (ex_mem_op),
        .ex_out      (ex_out),
        .ex_w_data   (ex_w_data),
        .bus         (bus),
        .busy        (busy),
        .access_req  (access_req),
        .miss_align  (miss_align),
        .discard     (discard),
        .state       (fsm_state)
    );

    // Forwarding taps straight off the pipeline register.
    always_comb begin
        fwd_addr = mem_w_addr;
        fwd_out  = mem_out;
    end

    // MEM/WB register: flush beats stall, stall holds, a pending or
    // discarded bus cycle inserts a bubble, otherwise capture EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_      <= 1'b1;
            mem_gpr_we_  <= 1'b1;
            mem_w_addr   <= '0;
            mem_exp_code <= EXP_NONE;
            mem_ctrl_op  <= CTRL_NONE;
            mem_out      <= '0;
        end else if (flush) begin
            mem_en_     <= 1'b1;
            mem_gpr_we_ <= 1'b1;
        end else if (stall) begin
            mem_en_ <= mem_en_;
        end else if (busy || discard || ex_en_) begin
            mem_en_ <= 1'b1;
        end else begin
            mem_en_      <= 1'b0;
            mem_w_addr   <= ex_w_addr;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_exp_code <= miss_align ? EXP_MISS_ALIGN : ex_exp_code;
            mem_gpr_we_  <= miss_align ? 1'b1 : ex_gpr_we_;
            mem_out      <= (access_req && (ex_mem_op == MEM_LW)) ? bus.bus_rd_data : ex_out;
        end
    end

endmodule

// File: tb/tb_yutorina_mem_stage.sv
// Directed bench for the MEM stage with an expected-result queue.
module tb_yutorina_mem_stage;
    import yutorina_mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_en_;
    logic [4:0]  ex_w_addr;
    logic [31:0] ex_w_data;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_ctrl_op;
    logic [31:0] ex_out;
    logic        busy;
    logic        mem_en_;
    logic [4:0]  mem_w_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [1:0]  mem_ctrl_op;
    logic [31:0] mem_out;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_out;
    bus_state_t  fsm_state;

    yutorina_mem_stage_if bus_i ();

    yutorina_mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_en_       (ex_en_),
        .ex_w_addr    (ex_w_addr),
        .ex_w_data    (ex_w_data),
        .ex_gpr_we_   (ex_gpr_we_),
        .ex_exp_code  (ex_exp_code),
        .ex_mem_op    (ex_mem_op),
        .ex_ctrl_op   (ex_ctrl_op),
        .ex_out       (ex_out),
        .bus          (bus_i),
        .busy         (busy),
        .mem_en_      (mem_en_),
        .mem_w_addr   (mem_w_addr),
        .mem_gpr_we_  (mem_gpr_we_),
        .mem_exp_code (mem_exp_code),
        .mem_ctrl_op  (mem_ctrl_op),
        .mem_out      (mem_out),
        .fwd_addr     (fwd_addr),
        .fwd_out      (fwd_out),
        .fsm_state    (fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [43:0] exp_q[$];
    logic [43:0] last;

    // {en_, gpr_we_, w_addr, exp_code, ctrl_op, out}
    function automatic logic [43:0] mk(input logic en, input logic we, input logic [4:0] wa,
                                       input logic [2:0] ec, input logic [1:0] co, input logic [31:0] o);
        return {en, we, wa, ec, co, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [43:0] v);
        exp_q.push_back(v);
        last = v;
    endtask

    task automatic check_mem(input string tag);
        logic [43:0] e;
        logic [43:0] act;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e   = exp_q.pop_front();
            act = {mem_en_, mem_gpr_we_, mem_w_addr, mem_exp_code, mem_ctrl_op, mem_out};
            check(tag, {20'd0, act}, {20'd0, e});
            check({tag, "_fwd"}, {27'd0, fwd_addr, fwd_out}, {27'd0, e[41:37], e[31:0]});
        end
    endtask

    task automatic drive_ex(input logic en, input logic [4:0] wa, input logic [31:0] wd, input logic we,
                            input logic [2:0] ec, input logic [1:0] mop, input logic [1:0] co,
                            input logic [31:0] o);
        ex_en_      = en;
        ex_w_addr   = wa;
        ex_w_data   = wd;
        ex_gpr_we_  = we;
        ex_exp_code = ec;
        ex_mem_op   = mop;
        ex_ctrl_op  = co;
        ex_out      = o;
    endtask

    initial begin
        logic [31:0] r_out;
        logic [4:0]  r_wa;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bus_i.bus_rdy_ = 1'b1;
        bus_i.bus_rd_data = 32'h0;
        drive_ex(1'b1, 5'd0, 32'd0, 1'b1, 3'd0, 2'd0, 2'd0, 32'd0);
        repeat (3) tick();

        // reset state
        push(mk(1'b1, 1'b1, 5'd0, 3'd0, 2'd0, 32'd0));
        check_mem("reset_regs");
        check("reset_req", {63'd0, bus_i.bus_req_}, 64'd1);
        check("reset_state", {63'd0, fsm_state}, {63'd0, IDLE});
        rst = 1'b0;

        // ALU op, one-cycle pass-through
        drive_ex(1'b0, 5'd3, 32'd0, 1'b0, 3'd0, MEM_NONE, 2'd2, 32'h1234);
        push(mk(1'b0, 1'b0, 5'd3, 3'd0, 2'd2, 32'h1234));
        @(negedge clk);
        check("alu_busy", {63'd0, busy}, 64'd0);
        check("alu_req", {63'd0, bus_i.bus_req_}, 64'd1);
        tick();
        check_mem("alu_result");

        // random ALU ops
        for (int i = 0; i < 4; i++) begin
            r_out = $urandom_range(32'h7fff_ffff, 0);
            r_wa  = 5'($urandom_range(31, 0));
            drive_ex(1'b0, r_wa, 32'd0, 1'b0, 3'd0, MEM_NONE, 2'd1, r_out);
            push(mk(1'b0, 1'b0, r_wa, 3'd0, 2'd1, r_out));
            tick();
            check_mem("alu_rand");
        end

        // LW with two wait cycles
        bus_i.bus_rd_data = 32'hCAFEBABE;
        drive_ex(1'b0, 5'd7, 32'd0, 1'b0, 3'd0, MEM_LW, 2'd0, 32'h100);
        @(negedge clk);
        check("lw_req", {63'd0, bus_i.bus_req_}, 64'd0);
        check("lw_addr", {34'd0, bus_i.bus_addr}, 64'h40);
        check("lw_rw", {63'd0, bus_i.bus_rw}, 64'd1);
        check("lw_busy1", {63'd0, busy}, 64'd1);
        tick();
        check("lw_bubble", {63'd0, mem_en_}, 64'd1);
        @(negedge clk);
        check("lw_busy2", {63'd0, busy}, 64'd1);
        check("lw_state", {63'd0, fsm_state}, {63'd0, ACCESS});
        tick();
        bus_i.bus_rdy_ = 1'b0;
        push(mk(1'b0, 1'b0, 5'd7, 3'd0, 2'd0, 32'hCAFEBABE));
        @(negedge clk);
        check("lw_busy3", {63'd0, busy}, 64'd0);
        tick();
        check_mem("lw_result");
        bus_i.bus_rdy_ = 1'b1;

        // misaligned SW
        drive_ex(1'b0, 5'd9, 32'h1111, 1'b0, 3'd0, MEM_SW, 2'd1, 32'h203);
        push(mk(1'b0, 1'b1, 5'd9, 3'd4, 2'd1, 32'h203));
        @(negedge clk);
        check("mis_req", {63'd0, bus_i.bus_req_}, 64'd1);
        check("mis_busy", {63'd0, busy}, 64'd0);
        tick();
        check_mem("mis_result");

        // zero-wait SW
        bus_i.bus_rdy_ = 1'b0;
        drive_ex(1'b0, 5'd2, 32'h55AA, 1'b1, 3'd0, MEM_SW, 2'd0, 32'h80);
        push(mk(1'b0, 1'b1, 5'd2, 3'd0, 2'd0, 32'h80));
        @(negedge clk);
        check("sw_req", {63'd0, bus_i.bus_req_}, 64'd0);
        check("sw_rw", {63'd0, bus_i.bus_rw}, 64'd0);
        check("sw_wdata", {32'd0, bus_i.bus_wr_data}, 64'h55AA);
        check("sw_busy", {63'd0, busy}, 64'd0);
        tick();
        check_mem("sw_result");
        bus_i.bus_rdy_ = 1'b1;

        // incoming exception suppresses the load and passes through
        bus_i.bus_rd_data = 32'hDEADBEEF;
        drive_ex(1'b0, 5'd5, 32'd0, 1'b0, 3'd2, MEM_LW, 2'd3, 32'h10);
        push(mk(1'b0, 1'b0, 5'd5, 3'd2, 2'd3, 32'h10));
        @(negedge clk);
        check("exc_req", {63'd0, bus_i.bus_req_}, 64'd1);
        tick();
        check_mem("exc_result");

        // invalid EX: bubble, other fields hold
        drive_ex(1'b1, 5'd11, 32'd0, 1'b0, 3'd0, MEM_NONE, 2'd1, 32'h4444);
        push(last | (44'd1 << 43));
        tick();
        check_mem("invalid_ex");

        // stall holds everything, release then loads
        drive_ex(1'b0, 5'd12, 32'd0, 1'b0, 3'd0, MEM_NONE, 2'd2, 32'h999);
        stall = 1'b1;
        push(last);
        tick();
        check_mem("stall_hold");
        stall = 1'b0;
        push(mk(1'b0, 1'b0, 5'd12, 3'd0, 2'd2, 32'h999));
        tick();
        check_mem("stall_release");

        // flush beats stall
        drive_ex(1'b0, 5'd4, 32'd0, 1'b0, 3'd0, MEM_NONE, 2'd1, 32'h777);
        stall = 1'b1;
        flush = 1'b1;
        push(last | (44'd3 << 42));
        tick();
        check_mem("flush_over_stall");
        stall = 1'b0;
        flush = 1'b0;

        // flush during the second wait cycle of a load
        bus_i.bus_rd_data = 32'hBEEF0001;
        drive_ex(1'b0, 5'd8, 32'd0, 1'b0, 3'd0, MEM_LW, 2'd0, 32'h104);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("fl_req1", {63'd0, bus_i.bus_req_}, 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("fl_req2", {63'd0, bus_i.bus_req_}, 64'd0);
        check("fl_state", {63'd0, fsm_state}, {63'd0, ACCESS});
        tick();
        bus_i.bus_rdy_ = 1'b0;
        push(last | (44'd3 << 42));
        @(negedge clk);
        check("fl_req3", {63'd0, bus_i.bus_req_}, 64'd0);
        tick();
        check_mem("fl_discard");
        bus_i.bus_rdy_ = 1'b1;
        ex_en_ = 1'b1;
        @(negedge clk);
        check("fl_req_after", {63'd0, bus_i.bus_req_}, 64'd1);
        tick();

        // load some state, then reset in the middle of an access
        drive_ex(1'b0, 5'd6, 32'd0, 1'b0, 3'd0, MEM_NONE, 2'd3, 32'hABCD);
        push(mk(1'b0, 1'b0, 5'd6, 3'd0, 2'd3, 32'hABCD));
        tick();
        check_mem("pre_reset_load");
        drive_ex(1'b0, 5'd6, 32'd0, 1'b0, 3'd0, MEM_LW, 2'd3, 32'h200);
        tick();
        check("rst_access", {63'd0, fsm_state}, {63'd0, ACCESS});
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_comb", {63'd0, bus_i.bus_req_}, 64'd1);
        push(mk(1'b1, 1'b1, 5'd0, 3'd0, 2'd0, 32'd0));
        tick();
        check_mem("rst_mid_access");
        check("rst_state_idle", {63'd0, fsm_state}, {63'd0, IDLE});
        rst = 1'b0;
        ex_en_ = 1'b1;
        @(negedge clk);
        check("rst_req_after", {63'd0, bus_i.bus_req_}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
